// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor controller.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa.sv
// Single-bit full adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one fa cell reused LSB-first over WIDTH cycles.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  state_t             state, state_nx;
  logic               accept;
  logic [WIDTH-1:0]   a_sh, b_sh, res_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               last_bit;
  logic               fa_sum, fa_carry;

  fa u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        accept   = start;
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Subtraction is a + ~b + 1: invert B at load and force the initial carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sh   <= op_a;
      b_sh   <= sub ? ~op_b : op_b;
      carry  <= sub ? 1'b1 : cin;
      cnt    <= '0;
      res_sh <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
      carry  <= fa_carry;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        result <= {fa_sum, res_sh[WIDTH-1:1]};
        cout   <= fa_carry;
      end
    end
  end

endmodule
